// File: rtl/writeback_stage.sv
// Writeback stage: buffers result beats in a small FIFO, computing address and
// byte enables at push time, and drains them to the vector register file in order.
module writeback_stage #(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] arith_result,
    input  logic [127:0] replicated_scalar,
    input  logic         use_scalar,
    input  logic         reduction,
    input  logic [1:0]   in_beat,
    input  logic         in_last,
    input  logic [4:0]   vd_addr,
    input  logic [4:0]   vl,
    input  logic [1:0]   vsew,
    output logic         rf_wr_en,
    input  logic         rf_ready,
    output logic [4:0]   rf_wr_addr,
    output logic [127:0] rf_wr_data,
    output logic [15:0]  rf_byte_en,
    output logic         done,
    output logic         sew_error
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [127:0]  mem_data [DEPTH];
    logic [4:0]    mem_addr [DEPTH];
    logic [15:0]   mem_be   [DEPTH];
    logic          mem_last [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          push;
    logic          pop;
    logic          empty;
    logic [15:0]   head_be;

    // Push-time decode of address and byte enables
    logic [6:0]    epr;
    logic [6:0]    beat_base;
    logic [6:0]    remaining;
    logic [6:0]    n_elem;
    logic [6:0]    n_bytes;
    logic [16:0]   be_mask;
    logic [4:0]    push_addr;
    logic [15:0]   push_be;

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        epr       = 7'd16 >> vsew;
        beat_base = 7'(in_beat) * epr;
        remaining = 7'(vl) - beat_base;
        push_addr = vd_addr + 5'(in_beat);
        n_elem    = '0;
        if (vsew == 2'd3) begin
            n_elem = '0;
        end else if (reduction) begin
            push_addr = vd_addr;
            n_elem    = in_last ? 7'd1 : 7'd0;
        end else if (7'(vl) > beat_base) begin
            n_elem = (remaining > epr) ? epr : remaining;
        end
        n_bytes = n_elem << vsew;
        be_mask = (17'd1 << n_bytes) - 17'd1;
        push_be = be_mask[15:0];
    end

    assign empty    = (count == '0);
    assign in_ready = (count < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign head_be  = mem_be[rd_ptr];
    // Entries with no enabled bytes retire silently without waiting on the register file
    assign pop      = !empty && (!(|head_be) || rf_ready);

    assign rf_wr_en   = !empty && (|head_be);
    assign rf_wr_addr = empty ? '0 : mem_addr[rd_ptr];
    assign rf_wr_data = empty ? '0 : mem_data[rd_ptr];
    assign rf_byte_en = empty ? '0 : head_be;

    // NOTE: the storage array has no reset; outputs are gated by occupancy so stale contents never leak.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= use_scalar ? replicated_scalar : arith_result;
            mem_addr[wr_ptr] <= push_addr;
            mem_be[wr_ptr]   <= push_be;
            mem_last[wr_ptr] <= in_last;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            done      <= 1'b0;
            sew_error <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            done      <= pop && mem_last[rd_ptr];
            sew_error <= push && (vsew == 2'd3);
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage (DEPTH = 2).
module tb_writeback_stage;

    logic         clk = 1'b0;
    logic         n_reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] arith_result;
    logic [127:0] replicated_scalar;
    logic         use_scalar;
    logic         reduction;
    logic [1:0]   in_beat;
    logic         in_last;
    logic [4:0]   vd_addr;
    logic [4:0]   vl;
    logic [1:0]   vsew;
    logic         rf_wr_en;
    logic         rf_ready;
    logic [4:0]   rf_wr_addr;
    logic [127:0] rf_wr_data;
    logic [15:0]  rf_byte_en;
    logic         done;
    logic         sew_error;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [127:0] D0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] D1 = 128'hA5A5_A5A5_1111_2222_3333_4444_5A5A_5A5A;
    localparam logic [127:0] D2 = 128'hDEAD_BEEF_CAFE_F00D_0BAD_F00D_1234_5678;
    localparam logic [127:0] SC = 128'h7777_7777_7777_7777_7777_7777_7777_7777;

    writeback_stage #(.DEPTH(2)) dut (
        .clk               (clk),
        .n_reset           (n_reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .arith_result      (arith_result),
        .replicated_scalar (replicated_scalar),
        .use_scalar        (use_scalar),
        .reduction         (reduction),
        .in_beat           (in_beat),
        .in_last           (in_last),
        .vd_addr           (vd_addr),
        .vl                (vl),
        .vsew              (vsew),
        .rf_wr_en          (rf_wr_en),
        .rf_ready          (rf_ready),
        .rf_wr_addr        (rf_wr_addr),
        .rf_wr_data        (rf_wr_data),
        .rf_byte_en        (rf_byte_en),
        .done              (done),
        .sew_error         (sew_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic red, input logic [1:0] beat, input logic last,
                            input logic [4:0] vd, input logic [4:0] len, input logic [1:0] sew,
                            input logic [127:0] data, input logic scal);
        in_valid     = 1'b1;
        reduction    = red;
        in_beat      = beat;
        in_last      = last;
        vd_addr      = vd;
        vl           = len;
        vsew         = sew;
        arith_result = data;
        use_scalar   = scal;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".in_ready"},  in_ready,   1'b1);
        check({tag, ".wr_en"},     rf_wr_en,   1'b0);
        check({tag, ".addr"},      rf_wr_addr, 5'd0);
        check({tag, ".data"},      rf_wr_data, 128'd0);
        check({tag, ".be"},        rf_byte_en, 16'd0);
        check({tag, ".done"},      done,       1'b0);
        check({tag, ".sew_err"},   sew_error,  1'b0);
    endtask

    initial begin
        n_reset = 1'b0; in_valid = 1'b0; rf_ready = 1'b1;
        arith_result = '0; replicated_scalar = SC; use_scalar = 1'b0;
        reduction = 1'b0; in_beat = '0; in_last = 1'b0;
        vd_addr = '0; vl = '0; vsew = '0;
        #3;
        check_idle_outputs("reset");
        tick();
        n_reset = 1'b1;

        // Single 32-bit beat, full register
        set_beat(1'b0, 2'd0, 1'b1, 5'd5, 5'd4, 2'd2, D0, 1'b0);
        tick();
        in_valid = 1'b0;
        check("t1.wr_en", rf_wr_en, 1'b1);
        check("t1.addr",  rf_wr_addr, 5'd5);
        check("t1.be",    rf_byte_en, 16'hFFFF);
        check("t1.data",  rf_wr_data, D0);
        check("t1.done0", done, 1'b0);
        tick();
        check("t1.done1", done, 1'b1);
        check("t1.idle",  rf_wr_en, 1'b0);
        tick();
        check("t1.done2", done, 1'b0);

        // Byte elements, address wraps 31 -> 0, scalar data, partial tail
        set_beat(1'b0, 2'd0, 1'b0, 5'd31, 5'd20, 2'd0, D1, 1'b1);
        tick();
        check("t2.addr0", rf_wr_addr, 5'd31);
        check("t2.be0",   rf_byte_en, 16'hFFFF);
        check("t2.data0", rf_wr_data, SC);
        set_beat(1'b0, 2'd1, 1'b1, 5'd31, 5'd20, 2'd0, D1, 1'b1);
        tick();
        in_valid = 1'b0;
        check("t2.wr_en1", rf_wr_en, 1'b1);
        check("t2.addr1",  rf_wr_addr, 5'd0);
        check("t2.be1",    rf_byte_en, 16'h000F);
        tick();
        check("t2.done",   done, 1'b1);

        // Reduction: only the last beat writes element 0
        set_beat(1'b1, 2'd0, 1'b0, 5'd3, 5'd8, 2'd1, D2, 1'b0);
        tick();
        check("t3.b0_nowr", rf_wr_en, 1'b0);
        set_beat(1'b1, 2'd1, 1'b0, 5'd3, 5'd8, 2'd1, D2, 1'b0);
        tick();
        check("t3.b1_nowr", rf_wr_en, 1'b0);
        set_beat(1'b1, 2'd2, 1'b1, 5'd3, 5'd8, 2'd1, D2, 1'b0);
        tick();
        in_valid = 1'b0;
        check("t3.wr_en", rf_wr_en, 1'b1);
        check("t3.addr",  rf_wr_addr, 5'd3);
        check("t3.be",    rf_byte_en, 16'h0003);
        tick();
        check("t3.done",  done, 1'b1);
        check("t3.empty", rf_wr_en, 1'b0);

        // Backpressure: fill, hold stable, drain in order
        rf_ready = 1'b0;
        set_beat(1'b0, 2'd0, 1'b0, 5'd10, 5'd16, 2'd2, D0, 1'b0);
        tick();
        check("t4.rdy1", in_ready, 1'b1);
        set_beat(1'b0, 2'd1, 1'b0, 5'd10, 5'd16, 2'd2, D1, 1'b0);
        tick();
        set_beat(1'b0, 2'd2, 1'b1, 5'd10, 5'd16, 2'd2, D2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("t4.full",      in_ready,   1'b0);
            check("t4.hold_en",   rf_wr_en,   1'b1);
            check("t4.hold_addr", rf_wr_addr, 5'd10);
            check("t4.hold_data", rf_wr_data, D0);
            if (i < 3) tick();
        end
        rf_ready = 1'b1;
        tick();
        check("t4.addr1", rf_wr_addr, 5'd11);
        check("t4.data1", rf_wr_data, D1);
        check("t4.rdy2",  in_ready,   1'b1);
        tick();
        in_valid = 1'b0;
        check("t4.addr2", rf_wr_addr, 5'd12);
        check("t4.data2", rf_wr_data, D2);
        check("t4.be2",   rf_byte_en, 16'hFFFF);
        tick();
        check("t4.done",  done, 1'b1);

        // Reserved element width
        set_beat(1'b0, 2'd0, 1'b1, 5'd9, 5'd4, 2'd3, D0, 1'b0);
        tick();
        in_valid = 1'b0;
        check("t5.sew_err", sew_error, 1'b1);
        check("t5.nowr",    rf_wr_en,  1'b0);
        tick();
        check("t5.sew_clr", sew_error, 1'b0);
        check("t5.done",    done,      1'b1);

        // Beat beyond vl: nothing to write, done still pulses
        set_beat(1'b0, 2'd1, 1'b1, 5'd4, 5'd4, 2'd2, D0, 1'b0);
        tick();
        in_valid = 1'b0;
        check("t6.nowr", rf_wr_en, 1'b0);
        tick();
        check("t6.done", done, 1'b1);

        // Reset with two entries buffered
        rf_ready = 1'b0;
        set_beat(1'b0, 2'd0, 1'b0, 5'd7, 5'd8, 2'd2, D1, 1'b0);
        tick();
        set_beat(1'b0, 2'd1, 1'b1, 5'd7, 5'd8, 2'd2, D2, 1'b0);
        tick();
        in_valid = 1'b0;
        check("t7.pre_full", in_ready, 1'b0);
        n_reset = 1'b0;
        #1;
        check_idle_outputs("t7.rst");
        tick();
        n_reset  = 1'b1;
        rf_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t7.no_wr", rf_wr_en, 1'b0);
            check("t7.no_done", done, 1'b0);
        end
        set_beat(1'b0, 2'd0, 1'b1, 5'd2, 5'd3, 2'd1, D0, 1'b0);
        tick();
        in_valid = 1'b0;
        check("t7.new_addr", rf_wr_addr, 5'd2);
        check("t7.new_be",   rf_byte_en, 16'h003F);
        check("t7.new_data", rf_wr_data, D0);
        tick();
        check("t7.new_done", done, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
